// File: rtl/adder_subtractor_pkg.sv
// Shared definitions for the AXI4-Lite adder/subtractor peripheral:
// register word offsets, response codes, control/status bit positions,
// the write-path state type and small data helpers.
package adder_subtractor_pkg;

  // Register word indices taken from address bits [4:2].
  localparam logic [2:0] ADDR_OPA    = 3'd0;
  localparam logic [2:0] ADDR_OPB    = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_SUB_BIT   = 0;
  localparam int CTRL_START_BIT = 1;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int STATUS_CARRY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_ERR_BIT   = 4;

  // Write path: which holds are filled, or waiting on the B handshake.
  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  // Merge new_val into old_val byte by byte under the write strobes.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_val[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_val[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Assemble the STATUS register image; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic busy,
                                              input logic done,
                                              input logic carry,
                                              input logic ovf,
                                              input logic err);
    logic [31:0] st;
    st = 32'd0;
    st[STATUS_BUSY_BIT]  = busy;
    st[STATUS_DONE_BIT]  = done;
    st[STATUS_CARRY_BIT] = carry;
    st[STATUS_OVF_BIT]   = ovf;
    st[STATUS_ERR_BIT]   = err;
    return st;
  endfunction

endpackage

// File: rtl/adder_subtractor_s_axi_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the
// adder/subtractor register slave. Clock and reset stay outside.
interface adder_subtractor_s_axi_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/adder_subtractor_core.sv
// Two-stage add/subtract pipeline. Stage 1 captures the operands and the
// operation on start; stage 2 registers the 33-bit result, carry/borrow,
// signed overflow and a one-cycle done pulse.
module adder_subtractor_core
  import adder_subtractor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        carry,
  output logic        ovf,
  output logic        done
);

  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sub_r;
  logic        v1_r;
  logic [32:0] sum_s;
  logic        ovf_s;
  logic [31:0] result_r;
  logic        carry_r;
  logic        ovf_r;
  logic        done_r;

  // Arithmetic on the stage-1 operands; bit 32 is carry on add, borrow on sub.
  always_comb begin
    sum_s = 33'd0;
    ovf_s = 1'b0;
    if (sub_r) begin
      sum_s = {1'b0, a_r} - {1'b0, b_r};
      ovf_s = (a_r[31] != b_r[31]) && (sum_s[31] != a_r[31]);
    end else begin
      sum_s = {1'b0, a_r} + {1'b0, b_r};
      ovf_s = (a_r[31] == b_r[31]) && (sum_s[31] != a_r[31]);
    end
  end

  // Stage 1: snapshot operands so later OPA/OPB writes cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      sub_r <= 1'b0;
      v1_r  <= 1'b0;
    end else begin
      if (start) begin
        a_r   <= a;
        b_r   <= b;
        sub_r <= sub;
      end
      v1_r <= start;
    end
  end

  // Stage 2: register the result and flags, pulse done alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 32'd0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (v1_r) begin
        result_r <= sum_s[31:0];
        carry_r  <= sum_s[32];
        ovf_r    <= ovf_s;
      end
      done_r <= v1_r;
    end
  end

  assign result = result_r;
  assign carry  = carry_r;
  assign ovf    = ovf_r;
  assign done   = done_r;

endmodule

// File: rtl/adder_subtractor_s_axi.sv
// AXI4-Lite slave for the adder/subtractor peripheral: one-entry AW and W
// holds, a registered B response, a single-beat read path and the
// OPA/OPB/CTRL/RESULT/STATUS register file around the compute core.
module adder_subtractor_s_axi
  import adder_subtractor_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  adder_subtractor_s_axi_if.slave   s_axi,
  output logic                      done_irq
);

  // Write path state and holds
  wr_state_e                       wr_state_r;
  logic                            awready_r;
  logic                            wready_r;
  logic                            bvalid_r;
  logic [1:0]                      bresp_r;
  logic [2:0]                      aw_idx_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_r;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_r;

  // Read path
  logic                            arready_r;
  logic                            rvalid_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_r;
  logic [1:0]                      rresp_r;

  // Register file and status
  logic [C_S_AXI_DATA_WIDTH-1:0]   opa_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   opb_r;
  logic                            sub_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   result_r;
  logic                            busy_r;
  logic                            done_r;
  logic                            carry_r;
  logic                            ovf_r;
  logic                            err_r;
  logic                            irq_r;
  logic                            start_go_r;

  logic                            aw_hs_s;
  logic                            w_hs_s;
  logic                            ar_hs_s;
  logic                            commit_s;
  logic                            start_req_s;
  logic                            start_go_s;
  logic [1:0]                      wr_resp_s;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data_s;
  logic [1:0]                      rd_resp_s;
  logic [31:0]                     core_result_s;
  logic                            core_carry_s;
  logic                            core_ovf_s;
  logic                            core_done_s;
  logic                            unused_s;

  assign aw_hs_s  = s_axi.S_AXI_AWVALID && awready_r;
  assign w_hs_s   = s_axi.S_AXI_WVALID && wready_r;
  assign ar_hs_s  = s_axi.S_AXI_ARVALID && arready_r;
  // A write lands on the first W_RESP cycle, the same edge BVALID rises.
  assign commit_s = (wr_state_r == W_RESP) && !bvalid_r;

  assign start_req_s = commit_s && (aw_idx_r == ADDR_CTRL) && wstrb_r[0]
                       && wdata_r[CTRL_START_BIT];
  assign start_go_s  = start_req_s && !busy_r;

  assign unused_s = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Write response code: only OPA, OPB and CTRL are writable.
  always_comb begin
    wr_resp_s = RESP_SLVERR;
    case (aw_idx_r)
      ADDR_OPA:  wr_resp_s = RESP_OKAY;
      ADDR_OPB:  wr_resp_s = RESP_OKAY;
      ADDR_CTRL: wr_resp_s = RESP_OKAY;
      default:   wr_resp_s = RESP_SLVERR;
    endcase
  end

  // Read mux over current register values; unmapped reads return zero.
  always_comb begin
    rd_data_s = 32'd0;
    rd_resp_s = RESP_OKAY;
    case (s_axi.S_AXI_ARADDR[4:2])
      ADDR_OPA:    rd_data_s = opa_r;
      ADDR_OPB:    rd_data_s = opb_r;
      ADDR_CTRL:   rd_data_s = {31'd0, sub_r};
      ADDR_RESULT: rd_data_s = result_r;
      ADDR_STATUS: rd_data_s = pack_status(busy_r, done_r, carry_r, ovf_r, err_r);
      default: begin
        rd_data_s = 32'd0;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Write FSM: fill AW/W holds in any order, commit, then hold B until BREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= 2'b00;
      aw_idx_r   <= 3'd0;
      wdata_r    <= 32'd0;
      wstrb_r    <= 4'd0;
    end else begin
      if (aw_hs_s) begin
        aw_idx_r <= s_axi.S_AXI_AWADDR[4:2];
      end
      if (w_hs_s) begin
        wdata_r <= s_axi.S_AXI_WDATA;
        wstrb_r <= s_axi.S_AXI_WSTRB;
      end
      case (wr_state_r)
        W_IDLE: begin
          if (aw_hs_s && w_hs_s) begin
            wr_state_r <= W_RESP;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
          end else if (aw_hs_s) begin
            wr_state_r <= W_HAVE_AW;
            awready_r  <= 1'b0;
            wready_r   <= 1'b1;
          end else if (w_hs_s) begin
            wr_state_r <= W_HAVE_W;
            awready_r  <= 1'b1;
            wready_r   <= 1'b0;
          end else begin
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
          end
        end
        W_HAVE_AW: begin
          awready_r <= 1'b0;
          if (w_hs_s) begin
            wr_state_r <= W_RESP;
            wready_r   <= 1'b0;
          end else begin
            wready_r   <= 1'b1;
          end
        end
        W_HAVE_W: begin
          wready_r <= 1'b0;
          if (aw_hs_s) begin
            wr_state_r <= W_RESP;
            awready_r  <= 1'b0;
          end else begin
            awready_r  <= 1'b1;
          end
        end
        W_RESP: begin
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          if (!bvalid_r) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wr_resp_s;
          end else if (s_axi.S_AXI_BREADY) begin
            bvalid_r   <= 1'b0;
            wr_state_r <= W_IDLE;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
          end
        end
        default: begin
          wr_state_r <= W_IDLE;
          awready_r  <= 1'b0;
          wready_r   <= 1'b0;
          bvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Read channel: capture data on AR handshake, hold until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= 2'b00;
    end else if (ar_hs_s) begin
      rvalid_r  <= 1'b1;
      arready_r <= 1'b0;
      rdata_r   <= rd_data_s;
      rresp_r   <= rd_resp_s;
    end else if (rvalid_r && s_axi.S_AXI_RREADY) begin
      rvalid_r  <= 1'b0;
      arready_r <= 1'b1;
    end else begin
      arready_r <= !rvalid_r;
    end
  end

  // Writable registers: OPA/OPB under byte strobes, CTRL.SUB on byte 0.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      opa_r <= 32'd0;
      opb_r <= 32'd0;
      sub_r <= 1'b0;
    end else if (commit_s) begin
      case (aw_idx_r)
        ADDR_OPA:  opa_r <= apply_wstrb(opa_r, wdata_r, wstrb_r);
        ADDR_OPB:  opb_r <= apply_wstrb(opb_r, wdata_r, wstrb_r);
        ADDR_CTRL: begin
          if (wstrb_r[0]) begin
            sub_r <= wdata_r[CTRL_SUB_BIT];
          end
        end
        default: ;
      endcase
    end
  end

  // Operation control: launch on START, flag ERR on START while busy,
  // and commit the core result one cycle after it leaves stage 2.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      start_go_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      carry_r    <= 1'b0;
      ovf_r      <= 1'b0;
      result_r   <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      start_go_r <= start_go_s;
      if (start_go_s) begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end else if (start_req_s) begin
        err_r  <= 1'b1;
      end
      if (core_done_s) begin
        busy_r   <= 1'b0;
        done_r   <= 1'b1;
        result_r <= core_result_s;
        carry_r  <= core_carry_s;
        ovf_r    <= core_ovf_s;
        irq_r    <= 1'b1;
      end else begin
        irq_r    <= 1'b0;
      end
    end
  end

  adder_subtractor_core u_core (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .start  (start_go_r),
    .sub    (sub_r),
    .a      (opa_r),
    .b      (opb_r),
    .result (core_result_s),
    .carry  (core_carry_s),
    .ovf    (core_ovf_s),
    .done   (core_done_s)
  );

  assign s_axi.S_AXI_AWREADY = awready_r;
  assign s_axi.S_AXI_WREADY  = wready_r;
  assign s_axi.S_AXI_BVALID  = bvalid_r;
  assign s_axi.S_AXI_BRESP   = bresp_r;
  assign s_axi.S_AXI_ARREADY = arready_r;
  assign s_axi.S_AXI_RVALID  = rvalid_r;
  assign s_axi.S_AXI_RDATA   = rdata_r;
  assign s_axi.S_AXI_RRESP   = rresp_r;
  assign done_irq            = irq_r;

endmodule

// File: tb/tb_adder_subtractor_s_axi.sv
// Self-checking bench for adder_subtractor_s_axi: table of operand/result
// vectors plus hand-written sequences for handshake ordering, error
// responses, back-to-back START and reset in the middle of a read.
module tb_adder_subtractor_s_axi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done_irq;

  always #5 clk = ~clk;

  adder_subtractor_s_axi_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();

  adder_subtractor_s_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .done_irq      (done_irq)
  );

  typedef struct {
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] ctrl;
    logic [31:0] res;
    logic [31:0] status;
  } vec_t;

  int n_cmp = 0;
  int n_mis = 0;
  int irq_cnt = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  // Count done_irq cycles.
  always @(negedge clk) begin
    if (done_irq === 1'b1) irq_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    logic aw_d, w_d, hs_aw, hs_w, got;
    logic [1:0] e;
    int t;
    bq.push_back(exp_resp);
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA = data;
    bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    aw_d = 1'b0; w_d = 1'b0; t = 0;
    while (!(aw_d && w_d) && t < 50) begin
      @(negedge clk);
      hs_aw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      hs_w  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge clk); #1;
      if (hs_aw) begin aw_d = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_d = 1'b1;  bus.S_AXI_WVALID = 1'b0; end
      t++;
    end
    chk($sformatf("wr_accept@%02h", addr), {30'd0, aw_d, w_d}, 32'd3);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    got = 1'b0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      if (bus.S_AXI_BVALID) begin
        got = 1'b1;
        e = bq.pop_front();
        chk($sformatf("bresp@%02h", addr), {30'd0, bus.S_AXI_BRESP}, {30'd0, e});
      end
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("bvalid_seen@%02h", addr), {31'd0, got}, 32'd1);
    if (!got) void'(bq.pop_front());
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    logic hs, got;
    logic [33:0] e;
    int t;
    rq.push_back({exp_resp, exp_data});
    bus.S_AXI_ARADDR = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    hs = 1'b0; t = 0;
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(posedge clk); #1;
      t++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    got = 1'b0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      if (bus.S_AXI_RVALID) begin
        got = 1'b1;
        e = rq.pop_front();
        chk($sformatf("rdata@%02h", addr), bus.S_AXI_RDATA, e[31:0]);
        chk($sformatf("rresp@%02h", addr), {30'd0, bus.S_AXI_RRESP}, {30'd0, e[33:32]});
      end
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("rvalid_seen@%02h", addr), {31'd0, got}, 32'd1);
    if (!got) void'(rq.pop_front());
    bus.S_AXI_RREADY = 1'b0;
  endtask

  // One write with the second channel presented gap cycles after the first,
  // and BREADY held low for four cycles once BVALID is up.
  task automatic split_write(input bit aw_first, input int gap,
                             input logic [4:0] addr, input logic [31:0] data);
    logic aw_d, w_d, hs_aw, hs_w, got;
    logic [1:0] e;
    int t;
    bq.push_back(2'b00);
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA = data;
    bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_BREADY = 1'b0;
    if (aw_first) bus.S_AXI_AWVALID = 1'b1;
    else          bus.S_AXI_WVALID = 1'b1;
    aw_d = 1'b0; w_d = 1'b0; t = 0;
    while (!(aw_d && w_d) && t < 40) begin
      @(negedge clk);
      hs_aw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      hs_w  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge clk); #1;
      if (hs_aw) begin aw_d = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_d = 1'b1;  bus.S_AXI_WVALID = 1'b0; end
      t++;
      if (t == gap) begin
        if (aw_first) bus.S_AXI_WVALID = 1'b1;
        else          bus.S_AXI_AWVALID = 1'b1;
      end
    end
    chk("split_accept", {30'd0, aw_d, w_d}, 32'd3);
    got = 1'b0; t = 0;
    while (!got && t < 20) begin
      @(negedge clk);
      got = bus.S_AXI_BVALID;
      t++;
    end
    chk("split_bvalid", {31'd0, got}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("b_hold_%0d", k),
          {28'd0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BRESP[1]},
          32'h8);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    e = bq.pop_front();
    chk("split_bresp", {30'd0, bus.S_AXI_BRESP}, {30'd0, e});
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    @(negedge clk);
    chk("split_bvalid_drop", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    @(negedge clk);
    chk("split_no_second_b", {31'd0, bus.S_AXI_BVALID}, 32'd0);
  endtask

  vec_t vt[6];

  initial begin
    int irq0;
    logic seen;
    logic got;
    int t;

    vt[0] = '{32'h00000005, 32'h00000003, 32'h2, 32'h00000008, 32'h02};
    vt[1] = '{32'h00000003, 32'h00000005, 32'h3, 32'hFFFFFFFE, 32'h06};
    vt[2] = '{32'h7FFFFFFF, 32'h00000001, 32'h2, 32'h80000000, 32'h0A};
    vt[3] = '{32'hFFFFFFFF, 32'h00000001, 32'h2, 32'h00000000, 32'h06};
    vt[4] = '{32'h80000000, 32'h00000001, 32'h3, 32'h7FFFFFFF, 32'h0A};
    vt[5] = '{32'h00000000, 32'h00000000, 32'h3, 32'h00000000, 32'h02};

    bus.S_AXI_AWADDR = 5'd0; bus.S_AXI_AWPROT = 3'd0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = 32'd0; bus.S_AXI_WSTRB = 4'd0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = 5'd0; bus.S_AXI_ARPROT = 3'd0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_handshakes",
        {26'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
         bus.S_AXI_ARREADY, bus.S_AXI_RVALID, done_irq}, 32'd0);
    chk("reset_rdata", bus.S_AXI_RDATA, 32'd0);
    chk("reset_resps", {28'd0, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(5'h10, 32'd0, 2'b00);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      axi_write(5'h00, vt[i].opa, 4'hF, 2'b00);
      axi_write(5'h04, vt[i].opb, 4'hF, 2'b00);
      irq0 = irq_cnt;
      axi_write(5'h08, vt[i].ctrl, 4'hF, 2'b00);
      seen = 1'b0;
      for (int k = 0; k < 3 && !seen; k++) begin
        @(negedge clk);
        if (done_irq === 1'b1) seen = 1'b1;
      end
      chk($sformatf("v%0d_irq_within_3", i), {31'd0, seen}, 32'd1);
      axi_read(5'h10, vt[i].status, 2'b00);
      axi_read(5'h0C, vt[i].res, 2'b00);
      axi_read(5'h08, vt[i].ctrl & 32'h1, 2'b00);
      chk($sformatf("v%0d_irq_count", i), irq_cnt - irq0, 32'd1);
    end

    // Channel ordering with BREADY stalled
    split_write(1'b0, 3, 5'h00, 32'h12345678);
    axi_read(5'h00, 32'h12345678, 2'b00);
    split_write(1'b1, 3, 5'h04, 32'h0F0F0F0F);
    axi_read(5'h04, 32'h0F0F0F0F, 2'b00);

    // START twice back to back: second is rejected with ERR
    axi_write(5'h00, 32'd10, 4'hF, 2'b00);
    axi_write(5'h04, 32'd4, 4'hF, 2'b00);
    irq0 = irq_cnt;
    axi_write(5'h08, 32'h2, 4'hF, 2'b00);
    axi_write(5'h08, 32'h2, 4'hF, 2'b00);
    repeat (8) @(negedge clk);
    chk("b2b_irq_count", irq_cnt - irq0, 32'd1);
    axi_read(5'h10, 32'h12, 2'b00);
    axi_read(5'h0C, 32'd14, 2'b00);

    // Read-only and unmapped accesses, byte strobes
    axi_write(5'h0C, 32'hDEADBEEF, 4'hF, 2'b10);
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 2'b10);
    axi_write(5'h14, 32'h55555555, 4'hF, 2'b10);
    axi_read(5'h14, 32'd0, 2'b10);
    axi_read(5'h0C, 32'd14, 2'b00);
    axi_read(5'h10, 32'h12, 2'b00);
    axi_write(5'h00, 32'd0, 4'hF, 2'b00);
    axi_write(5'h00, 32'hAABBCCDD, 4'b0010, 2'b00);
    axi_read(5'h00, 32'h0000CC00, 2'b00);

    // Reset while a read response is stalled
    bus.S_AXI_ARADDR = 5'h00;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY = 1'b0;
    got = 1'b0; t = 0;
    while (!got && t < 20) begin
      @(negedge clk);
      if (bus.S_AXI_ARREADY) begin
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
      end
      got = bus.S_AXI_RVALID;
      t++;
    end
    chk("stall_rvalid", {31'd0, got}, 32'd1);
    bus.S_AXI_ARVALID = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_valids",
        {26'd0, bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
         bus.S_AXI_AWREADY, bus.S_AXI_WREADY, done_irq}, 32'd0);
    chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(5'h00, 32'd0, 2'b00);
    axi_read(5'h04, 32'd0, 2'b00);
    axi_read(5'h08, 32'd0, 2'b00);
    axi_read(5'h0C, 32'd0, 2'b00);
    axi_read(5'h10, 32'd0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Overall time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
